// File: rtl/boot_sequencer.sv
// Bring-up/tear-down sequencer: memory reset, image load, staggered unit reset
// release, control-unit hold, run, image dump, done. All outputs registered.
module boot_sequencer #(
  parameter int N_UNITS     = 6,
  parameter int CNT_W       = 16,
  parameter int MEMRST_CYC  = 1,
  parameter int LOAD_CYC    = 1,
  parameter int UNITRST_CYC = 1,
  parameter int STAGGER_CYC = 0,
  parameter int HOLD_CYC    = 1,
  parameter int RUN_CYC     = 4,
  parameter int DUMP_CYC    = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic               halt,
  output logic               mem_RESET,
  output logic               mem_read_file,
  output logic               mem_write_file,
  output logic [N_UNITS-1:0] unit_RESET,
  output logic               uc_RESET,
  output logic               running,
  output logic               done,
  output logic [CNT_W-1:0]   run_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_MEMRST, S_LOAD, S_UNITRST, S_RELEASE, S_HOLD, S_RUN, S_DUMP, S_DONE
  } state_t;

  // Zero stagger collapses the release phase to a single cycle for all units.
  localparam int REL_STEP = (STAGGER_CYC == 0) ? 0 : STAGGER_CYC + 1;

  localparam logic [CNT_W-1:0] MEMRST_LAST  = CNT_W'(((MEMRST_CYC  > 0) ? MEMRST_CYC  : 1) - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(((LOAD_CYC    > 0) ? LOAD_CYC    : 1) - 1);
  localparam logic [CNT_W-1:0] UNITRST_LAST = CNT_W'(((UNITRST_CYC > 0) ? UNITRST_CYC : 1) - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((N_UNITS - 1) * REL_STEP);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(((HOLD_CYC    > 0) ? HOLD_CYC    : 1) - 1);
  localparam logic [CNT_W-1:0] RUN_LAST     = CNT_W'(RUN_CYC - 1);
  localparam logic [CNT_W-1:0] DUMP_LAST    = CNT_W'(((DUMP_CYC    > 0) ? DUMP_CYC    : 1) - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  logic               mem_reset_d, read_d, write_d, uc_d, running_d, done_d;
  logic [N_UNITS-1:0] unit_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_MEMRST;
      S_MEMRST:  if (cnt == MEMRST_LAST)  state_nx = S_LOAD;
      S_LOAD:    if (cnt == LOAD_LAST)    state_nx = S_UNITRST;
      S_UNITRST: if (cnt == UNITRST_LAST) state_nx = S_RELEASE;
      S_RELEASE: if (cnt == RELEASE_LAST) state_nx = S_HOLD;
      S_HOLD:    if (cnt == HOLD_LAST)    state_nx = S_RUN;
      S_RUN:     if (halt || (RUN_CYC != 0 && cnt == RUN_LAST)) state_nx = S_DUMP;
      S_DUMP:    if (cnt == DUMP_LAST)    state_nx = S_DONE;
      default:   state_nx = S_IDLE;
    endcase
    cnt_nx = (state_nx != state) ? '0 : cnt + CNT_W'(1);
  end

  // Outputs are decoded from the upcoming state so the registered copy lines up with it.
  always_comb begin
    mem_reset_d = 1'b0;
    read_d      = 1'b0;
    write_d     = 1'b0;
    unit_d      = '1;
    uc_d        = 1'b1;
    running_d   = 1'b0;
    done_d      = 1'b0;
    case (state_nx)
      S_MEMRST: mem_reset_d = 1'b1;
      S_LOAD:   read_d      = 1'b1;
      S_RELEASE: begin
        for (int i = 0; i < N_UNITS; i++)
          unit_d[i] = (32'(cnt_nx) < 32'(i * REL_STEP));
      end
      S_HOLD: unit_d = '0;
      S_RUN: begin
        unit_d    = '0;
        uc_d      = 1'b0;
        running_d = 1'b1;
      end
      S_DUMP: begin
        unit_d  = '0;
        write_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_RESET      <= 1'b0;
      mem_read_file  <= 1'b0;
      mem_write_file <= 1'b0;
      unit_RESET     <= '1;
      uc_RESET       <= 1'b1;
      running        <= 1'b0;
      done           <= 1'b0;
    end else begin
      mem_RESET      <= mem_reset_d;
      mem_read_file  <= read_d;
      mem_write_file <= write_d;
      unit_RESET     <= unit_d;
      uc_RESET       <= uc_d;
      running        <= running_d;
      done           <= done_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      run_count <= '0;
    else if (state_nx == S_MEMRST && (state == S_IDLE || state == S_DONE))
      run_count <= '0;
    else if (state == S_RUN && run_count != '1)
      run_count <= run_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboarded random/directed bench for boot_sequencer: two parameterisations
// checked cycle by cycle against a phase-timeline reference model.
module tb_boot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n, s, m, l, u, h, run, d, cw;
  } prm_t;

  // Phase: 0 idle, 1 bring-up timeline, 2 run, 3 dump, 4 done
  typedef struct {
    int ph, t, r, dc, rc;
  } mst_t;

  typedef struct packed {
    logic        mr, rd, wr;
    logic [7:0]  unit;
    logic        uc, run, done;
    logic [15:0] rc;
  } exp_t;

  localparam prm_t PA = '{n:6, s:0, m:1, l:1, u:1, h:1, run:4, d:1, cw:16};
  localparam prm_t PB = '{n:4, s:2, m:2, l:3, u:0, h:2, run:0, d:3, cw:4};

  logic rst_a, start_a, halt_a, rst_b, start_b, halt_b;
  logic mr_a, rd_a, wr_a, uc_a, run_a, done_a;
  logic mr_b, rd_b, wr_b, uc_b, run_b, done_b;
  logic [5:0]  unit_a;
  logic [3:0]  unit_b;
  logic [15:0] rc_a;
  logic [3:0]  rc_b;

  boot_sequencer dut_a (
    .CLK(clk), .RESET(rst_a), .start(start_a), .halt(halt_a),
    .mem_RESET(mr_a), .mem_read_file(rd_a), .mem_write_file(wr_a),
    .unit_RESET(unit_a), .uc_RESET(uc_a), .running(run_a), .done(done_a),
    .run_count(rc_a)
  );

  boot_sequencer #(
    .N_UNITS(4), .CNT_W(4), .MEMRST_CYC(2), .LOAD_CYC(3), .UNITRST_CYC(0),
    .STAGGER_CYC(2), .HOLD_CYC(2), .RUN_CYC(0), .DUMP_CYC(3)
  ) dut_b (
    .CLK(clk), .RESET(rst_b), .start(start_b), .halt(halt_b),
    .mem_RESET(mr_b), .mem_read_file(rd_b), .mem_write_file(wr_b),
    .unit_RESET(unit_b), .uc_RESET(uc_b), .running(run_b), .done(done_b),
    .run_count(rc_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  exp_t qa[$];
  exp_t qb[$];

  function automatic int mx1(int v);
    return (v > 0) ? v : 1;
  endfunction

  function automatic int pre_run_len(prm_t p);
    int step = (p.s == 0) ? 0 : p.s + 1;
    return mx1(p.m) + mx1(p.l) + mx1(p.u) + (p.n - 1) * step + 1 + mx1(p.h);
  endfunction

  function automatic mst_t mstep(mst_t s, prm_t p, logic rst, logic st, logic hl);
    mst_t o = s;
    if (rst) begin
      o.ph = 0; o.rc = 0;
    end else begin
      case (s.ph)
        0, 4: if (st) begin o.ph = 1; o.t = 0; o.rc = 0; end
        1: begin
          o.t = s.t + 1;
          if (o.t == pre_run_len(p)) begin o.ph = 2; o.r = 0; end
        end
        2: begin
          o.rc = (s.rc + 1 > (1 << p.cw) - 1) ? (1 << p.cw) - 1 : s.rc + 1;
          o.r  = s.r + 1;
          if (hl || (p.run > 0 && o.r == p.run)) begin o.ph = 3; o.dc = 0; end
        end
        3: begin
          o.dc = s.dc + 1;
          if (o.dc == mx1(p.d)) o.ph = 4;
        end
        default: o.ph = 0;
      endcase
    end
    return o;
  endfunction

  function automatic exp_t mout(mst_t s, prm_t p);
    exp_t e = '0;
    int b1 = mx1(p.m);
    int b2 = b1 + mx1(p.l);
    int b3 = b2 + mx1(p.u);
    int step = (p.s == 0) ? 0 : p.s + 1;
    int b4 = b3 + (p.n - 1) * step + 1;
    logic [7:0] all1 = 8'((1 << p.n) - 1);
    e.unit = all1;
    e.uc   = 1'b1;
    e.rc   = 16'(s.rc);
    case (s.ph)
      1: begin
        if (s.t < b1)      e.mr = 1'b1;
        else if (s.t < b2) e.rd = 1'b1;
        else if (s.t < b3) e.unit = all1;
        else if (s.t < b4) begin
          for (int i = 0; i < p.n; i++) e.unit[i] = ((s.t - b3) < i * step);
        end else e.unit = '0;
      end
      2: begin e.unit = '0; e.uc = 1'b0; e.run = 1'b1; end
      3: begin e.unit = '0; e.wr = 1'b1; end
      4: e.done = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(string nm, exp_t act, exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got mr=%b rd=%b wr=%b unit=%b uc=%b run=%b done=%b rc=%0d want mr=%b rd=%b wr=%b unit=%b uc=%b run=%b done=%b rc=%0d",
               nm, cyc, act.mr, act.rd, act.wr, act.unit, act.uc, act.run, act.done, act.rc,
               exp.mr, exp.rd, exp.wr, exp.unit, exp.uc, exp.run, exp.done, exp.rc);
    end
    checks++;
    if ($countones({act.mr, act.rd, act.wr}) > 1) begin
      errors++;
      $display("FAIL %s_strobe_excl cyc=%0d got %b%b%b want at most one high",
               nm, cyc, act.mr, act.rd, act.wr);
    end
  endtask

  // Monitor: compare whatever the DUTs show against the oldest pending expectation.
  initial begin
    exp_t e, act;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (qa.size() > 0) begin
        e   = qa.pop_front();
        act = '{mr:mr_a, rd:rd_a, wr:wr_a, unit:8'(unit_a), uc:uc_a, run:run_a,
                done:done_a, rc:rc_a};
        chk("dut_a", act, e);
      end
      if (qb.size() > 0) begin
        e   = qb.pop_front();
        act = '{mr:mr_b, rd:rd_b, wr:wr_b, unit:8'(unit_b), uc:uc_b, run:run_b,
                done:done_b, rc:16'(rc_b)};
        chk("dut_b", act, e);
      end
    end
  end

  // Stimulus: directed scenarios first, then random traffic; model advances in lockstep.
  initial begin
    mst_t ma = '{ph:0, t:0, r:0, dc:0, rc:0};
    mst_t mb = '{ph:0, t:0, r:0, dc:0, rc:0};
    rst_a = 1'b1; start_a = 1'b0; halt_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; halt_b = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n < 200) begin
        rst_a   = (n < 3);
        start_a = (n == 4) || (n == 30);
        halt_a  = (ma.ph == 1 && ma.t == 1) || (n > 30 && ma.ph == 2 && ma.r == 3);
        rst_b   = (n < 3) || (n >= 120 && mb.ph == 3 && mb.dc == 1);
        start_b = (n == 4) || (n == 60) || (n == 120);
        halt_b  = (mb.ph == 1 && mb.t == 3) ||
                  (mb.ph == 2 && ((n < 60 && mb.r == 9) ||
                                  (n >= 60 && n < 120 && mb.r == 19) ||
                                  (n >= 120 && mb.r == 4)));
      end else begin
        rst_a   = ($urandom_range(199) == 0);
        start_a = ($urandom_range(9) == 0);
        halt_a  = ($urandom_range(15) == 0);
        rst_b   = ($urandom_range(199) == 0);
        start_b = ($urandom_range(9) == 0);
        halt_b  = ($urandom_range(7) == 0);
      end
      ma = mstep(ma, PA, rst_a, start_a, halt_a);
      mb = mstep(mb, PB, rst_b, start_b, halt_b);
      qa.push_back(mout(ma, PA));
      qb.push_back(mout(mb, PB));
    end
    repeat (2) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
